data_mem_responder: RTL and testbench

Responder for the CPU data port: accepts the core's byte-addressed load/store requests and serves them from an on-chip word RAM with byte-lane writes and fixed one-cycle read latency. It sits between the CPU data port and the rest of the system. It also decodes a small memory-mapped I/O window holding a GPIO output register and a free-running cycle counter. Bad requests are flagged on a registered error pulse.

---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-port responder.
// Serves byte-addressed loads/stores from an on-chip word RAM with byte-lane
// writes and a fixed one-cycle read latency. Bad requests (illegal lane mask,
// misalignment, unmapped address) produce a registered one-cycle err pulse.
// Optional MMIO window (GPIO register + free-running cycle counter) is built
// only when DATA_MEM_MMIO_EN is defined.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
`ifdef DATA_MEM_MMIO_EN
  ,
  output logic [31:0] gpio_out
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic          in_ram;
  logic          in_mmio;
  logic          mmio_ok;
  logic [31:0]   mmio_rd;
  logic          we_legal;
  logic          misalign;
  logic          fault;
  logic          is_rd;
  logic          is_wr;

  // registered response state
  logic [31:0]   ram_q;
  logic [31:0]   other_q;
  logic          src_ram_q;
  logic          rvalid_q;
  logic          err_q;

  assign widx   = addr[AW+1:2];
  assign in_ram = (addr[31:AW+2] == '0);

`ifdef DATA_MEM_MMIO_EN
  logic [1:0]  sel;
  logic [31:0] cycle_cnt;

  assign sel      = addr[3:2];
  assign in_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
  // only GPIO (0x0) and counter (0x4) are mapped; 0x8/0xC fault
  assign mmio_ok  = in_mmio & ~sel[1];
  assign mmio_rd  = sel[0] ? cycle_cnt : gpio_out;

  // free-running cycle counter, wraps naturally
  always_ff @(posedge aclk) begin
    if (areset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  // GPIO register with byte-lane writes; counter writes fall through unused
  always_ff @(posedge aclk) begin
    if (areset) begin
      gpio_out <= '0;
    end else if (is_wr && mmio_ok && sel == 2'd0) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) gpio_out[8*i +: 8] <= wdata[8*i +: 8];
    end
  end
`else
  assign in_mmio = 1'b0;
  assign mmio_ok = 1'b0;
  assign mmio_rd = '0;
`endif

  // lane masks the core is allowed to issue: none, byte, half, word
  always_comb begin
    we_legal = 1'b0;
    case (we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: we_legal = 1'b1;
      default:                   we_legal = 1'b0;
    endcase
  end

  // alignment, lane-mask and address-range fault decode
  always_comb begin
    misalign = ((we == 4'b1111) && (addr[1:0] != 2'b00)) ||
               (((we == 4'b0011) || (we == 4'b1100)) && addr[0]);
    fault    = ~we_legal | misalign | ~(in_ram | mmio_ok);
    is_rd    = en & ~areset & (we == 4'b0000);
    is_wr    = en & ~areset & (we != 4'b0000) & ~fault;
  end

  // RAM array: byte-lane writes, registered read; contents are never reset
  always_ff @(posedge aclk) begin
    if (is_wr && in_ram) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (is_rd && in_ram && !fault) ram_q <= mem[widx];
  end

  // response registers: non-RAM read data, source select, rvalid/err pulses
  always_ff @(posedge aclk) begin
    if (areset) begin
      other_q   <= '0;
      src_ram_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= is_rd;
      err_q    <= en & fault;
      if (is_rd) begin
        src_ram_q <= in_ram & ~fault;
        other_q   <= (fault || in_ram) ? 32'h0 : mmio_rd;
      end
    end
  end

  // a pulse owed from the previous cycle is squashed while reset is asserted
  assign rdata  = src_ram_q ? ram_q : other_q;
  assign rvalid = rvalid_q & ~areset;
  assign err    = err_q & ~areset;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// response for each request; a negedge monitor pops and compares whenever a
// response is due or the DUT raises rvalid/err.
module tb_data_mem_responder;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        aclk;
  logic        areset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
`ifdef DATA_MEM_MMIO_EN
  logic [31:0] gpio_out;
`endif

  data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .aclk   (aclk),
    .areset (areset),
    .en     (en),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err)
`ifdef DATA_MEM_MMIO_EN
    ,
    .gpio_out (gpio_out)
`endif
  );

  typedef struct {
    int          due;
    bit          rv;
    bit          er;
    logic [31:0] d;
    bit          cap;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] capq[$];
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;
  bit          mon_en = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // monitor: compare the due response, flag any unexpected pulse
  always @(negedge aclk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (rvalid !== e.rv || err !== e.er ||
            (e.rv && !e.cap && rdata !== e.d)) begin
          n_bad++;
          $display("FAIL resp@%0d: got rvalid=%0b err=%0b rdata=%h, want rvalid=%0b err=%0b rdata=%h",
                   cyc, rvalid, err, rdata, e.rv, e.er, e.d);
        end else if (e.cap) begin
          capq.push_back(rdata);
        end
      end else if (rvalid || err) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected@%0d: got rvalid=%0b err=%0b rdata=%h, want no response",
                 cyc, rvalid, err, rdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input bit rv, input bit er, input logic [31:0] ed, input bit cap);
    en = 1'b1; we = w; addr = a; wdata = d;
    if (rv || er) sb.push_back('{due: cyc + 1, rv: rv, er: er, d: ed, cap: cap});
  endtask

  task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input bit rv, input bit er, input logic [31:0] ed);
    @(posedge aclk); #1;
    drive(w, a, d, rv, er, ed, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      en = 1'b0; we = 4'h0;
    end
  endtask

  initial begin
    areset = 1'b1; en = 1'b0; we = 4'h0; addr = '0; wdata = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("reset_rdata",  rdata, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_err",    {31'h0, err}, 32'h0);
`ifdef DATA_MEM_MMIO_EN
    check("reset_gpio",   gpio_out, 32'h0);
`endif
    mon_en = 1'b1;

    // byte-lane merge
    issue(4'hF, 32'h10, 32'hAABB_CCDD, 0, 0, 0);
    issue(4'h2, 32'h10, 32'h0000_1100, 0, 0, 0);
    issue(4'h0, 32'h10, 32'h0,         1, 0, 32'hAABB_11DD);

    // back-to-back reads
    issue(4'hF, 32'h0, 32'd1, 0, 0, 0);
    issue(4'hF, 32'h4, 32'd2, 0, 0, 0);
    issue(4'hF, 32'h8, 32'd3, 0, 0, 0);
    issue(4'h0, 32'h0, 32'h0, 1, 0, 32'd1);
    issue(4'h0, 32'h4, 32'h0, 1, 0, 32'd2);
    issue(4'h0, 32'h8, 32'h0, 1, 0, 32'd3);
    idle(1);

    // misaligned word store faults and leaves memory untouched
    issue(4'hF, 32'h12, 32'h1234_5678, 0, 1, 0);
    issue(4'h0, 32'h10, 32'h0,         1, 0, 32'hAABB_11DD);
    // half stores: odd address faults, even address writes upper lanes
    issue(4'h3, 32'h11, 32'hFFFF_FFFF, 0, 1, 0);
    issue(4'hC, 32'h12, 32'h7788_0000, 0, 0, 0);
    issue(4'h0, 32'h10, 32'h0,         1, 0, 32'h7788_11DD);
    // illegal lane masks
    issue(4'h5, 32'h20, 32'h0, 0, 1, 0);
    issue(4'h6, 32'h20, 32'h0, 0, 1, 0);
    // unmapped read: both pulses, data zero
    issue(4'h0, 32'hFFFF_0000, 32'h0, 1, 1, 32'h0);
    idle(1);

    // RAM boundary: last word ok, first word past the end faults
    issue(4'hF, 32'hFFC,  32'hDEAD_BEEF, 0, 0, 0);
    issue(4'h0, 32'hFFC,  32'h0, 1, 0, 32'hDEAD_BEEF);
    issue(4'hF, 32'h1000, 32'h1, 0, 1, 0);
    issue(4'h0, 32'h1000, 32'h0, 1, 1, 32'h0);
    // read-after-write on the very next cycle
    issue(4'hF, 32'h40, 32'h1234_5678, 0, 0, 0);
    issue(4'h0, 32'h40, 32'h0, 1, 0, 32'h1234_5678);
    issue(4'h1, 32'h43, 32'h0000_00EE, 0, 0, 0);
    issue(4'h0, 32'h40, 32'h0, 1, 0, 32'h1234_56EE);
    idle(2);

`ifdef DATA_MEM_MMIO_EN
    issue(4'h1, MB, 32'h0000_005A, 0, 0, 0);
    @(negedge aclk);
    check("gpio_write", gpio_out, 32'h0000_005A);
    issue(4'h0, MB, 32'h0, 1, 0, 32'h0000_005A);
    issue(4'hF, MB + 32'h4, 32'h1234, 0, 0, 0);
    @(negedge aclk);
    check("cnt_write_no_err", {31'h0, err}, 32'h0);
    issue(4'h0, MB + 32'h8, 32'h0, 1, 1, 32'h0);
    // counter reads 10 request-cycles apart
    @(posedge aclk); #1;
    drive(4'h0, MB + 32'h4, 32'h0, 1, 0, 32'h0, 1'b1);
    idle(9);
    @(posedge aclk); #1;
    drive(4'h0, MB + 32'h4, 32'h0, 1, 0, 32'h0, 1'b1);
    idle(2);
    if (capq.size() == 2) check("cnt_delta", capq[1] - capq[0], 32'd10);
    else check("cnt_captures", capq.size(), 32'd2);
    // counter wrap
    @(posedge aclk); #1;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    release dut.cycle_cnt;
    drive(4'h0, MB + 32'h4, 32'h0, 1, 0, 32'hFFFF_FFFE, 1'b0);
    issue(4'h0, MB + 32'h4, 32'h0, 1, 0, 32'hFFFF_FFFF);
    issue(4'h0, MB + 32'h4, 32'h0, 1, 0, 32'h0);
    idle(2);
`endif

    // reset the cycle after a read: owed rvalid squashed, state cleared
    issue(4'h0, 32'h10, 32'h0, 0, 0, 0);
    @(posedge aclk); #1;
    areset = 1'b1; en = 1'b0; we = 4'h0;
    @(negedge aclk);
    check("midrst_rvalid", {31'h0, rvalid}, 32'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("midrst_rdata",  rdata, 32'h0);
    check("midrst_rvalid2", {31'h0, rvalid}, 32'h0);
`ifdef DATA_MEM_MMIO_EN
    check("midrst_gpio",   gpio_out, 32'h0);
`endif
    // RAM survives reset
    issue(4'h0, 32'h40, 32'h0, 1, 0, 32'h1234_56EE);
    idle(3);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
